tcp_rx_flow_table: RTL and testbench
====================================

Name: tcp_rx_flow_table

Overview:
- Parametrised flow-state table for the TCP receive path: 4-tuple to flowid lookup, plus flowid allocation and release.
- Replaces the fixed CAM-plus-write-only flowid manager pairing.
- Adds flowid return and recycling, duplicate-insert detection, an occupancy count, and a reset-time free-list initialisation sequence.
- Sits between the RX header parser/ctrl (lookup), the new-flow slow path (alloc) and the connection-teardown logic (free).

Parameters:
- MAX_FLOWS, 8, number of table entries; power of two, ≥2.
- FLOWID_W, $clog2(MAX_FLOWS), flowid width.
- TAG_W, FOUR_TUPLE_STRUCT_W, width of the four_tuple_struct key.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lookup_req_val  in  1  lookup request valid
- lookup_req_tag  in  TAG_W  4-tuple key
- lookup_req_rdy  out  1  lookup request ready
- lookup_resp_val  out  1  lookup result valid
- lookup_resp_hit  out  1  key present
- lookup_resp_flowid  out  FLOWID_W  matching flowid (0 on miss)
- lookup_resp_rdy  in  1  consumer ready
- alloc_req_val  in  1  insert request valid
- alloc_req_tag  in  TAG_W  key to insert
- alloc_req_rdy  out  1  insert request ready
- alloc_resp_val  out  1  insert result valid
- alloc_resp_ok  out  1  new entry created
- alloc_resp_dup  out  1  key already present
- alloc_resp_flowid  out  FLOWID_W  new flowid or existing flowid (0 if full)
- alloc_resp_rdy  in  1  consumer ready
- free_req_val  in  1  release request valid
- free_req_flowid  in  FLOWID_W  flowid to release
- free_req_rdy  out  1  release request ready
- err_double_free  out  1  one-cycle pulse: freed flowid was not valid
- occupancy  out  FLOWID_W+1  count of valid entries

Behaviour:
- Reset: all valid bits cleared; free-list write pointer cleared; occupancy=0; err_double_free=0; all resp_val=0; all req_rdy=0; FSM enters INIT.
- FSM INIT:
  - One free-list write per cycle, pushing flowids 0..MAX_FLOWS-1 in order; takes MAX_FLOWS cycles.
  - Then RUN. All rdy remain 0 throughout INIT.
- FSM RUN:
  - At most one operation accepted per cycle, fixed priority free > alloc > lookup.
  - A lower-priority rdy is 0 whenever a higher-priority val is 1.
- Response-channel gating:
  - lookup_req_rdy additionally requires the lookup response register to be empty, or to be draining this cycle (resp_val & resp_rdy).
  - alloc_req_rdy has the same rule on the alloc response register.
  - free_req_rdy is 1 in RUN whenever it has priority.
- Lookup:
  - Key compared against all valid entries combinationally.
  - Response registered; lookup_resp_val rises the cycle after acceptance (latency 1).
  - Response held stable until lookup_resp_rdy.
- Alloc, evaluated at acceptance:
  - Key hits: ok=0, dup=1, flowid=existing. No state change.
  - Else free list empty: ok=0, dup=0, flowid=0.
  - Else: pop head flowid, store tag, set valid, occupancy+1; ok=1, dup=0.
  - Response latency 1, held until alloc_resp_rdy.
- Free:
  - Entry valid: clear valid, push flowid to free-list tail, occupancy-1.
  - Entry invalid: no state change; err_double_free=1 for the following cycle.
- Ordering: an operation accepted in cycle N is visible to any operation accepted in cycle N+1 or later. Examples: a lookup after a free misses; an alloc after a free may reuse that flowid.
- Free list:
  - Circular FIFO of depth MAX_FLOWS with pointers of FLOWID_W+1 bits; wrap via the MSB.
  - Empty when pointers are equal. It can never overflow, because double-free is filtered.
  - Recycling order is FIFO: the oldest freed flowid is reused first.
- Occupancy equals MAX_FLOWS minus free-list count; it must never exceed MAX_FLOWS.
- Reset asserted mid-operation: pending responses dropped, table cleared, INIT restarts.

Decomposition:
- tcp_pkg gains:
  - flow_table_alloc_resp_struct {ok, dup, flowid}
  - FLOW_TABLE_PTR_W
- four_tuple_struct is reused from tcp_pkg.
- One sub-module: tcp_flow_free_list (circular FIFO with init-fill counter, push/pop, empty). The CAM match array stays inline.

Test Plan:
- Reset release, MAX_FLOWS=8 -> all rdy=0 for exactly 8 cycles, then rdy=1; occupancy=0.
- Alloc tag A, then lookup A -> alloc resp ok=1 flowid=0; lookup resp hit=1 flowid=0 one cycle after acceptance; lookup of unused tag B -> hit=0 flowid=0.
- Alloc 8 distinct tags, then a 9th -> flowids 0..7 in order, occupancy=8; 9th resp ok=0 dup=0.
- Alloc A twice -> second resp dup=1 ok=0 flowid=first flowid; occupancy unchanged.
- Fill table, free flowid 3, free 5, alloc C, alloc D -> C gets 3, D gets 5; lookup of the tag previously at 3 misses. Free 3 again after it is re-allocated and released -> no error; free an invalid flowid -> err_double_free pulses once, occupancy unchanged.
- Same-cycle free, alloc, lookup with lookup_resp_rdy held 0 for 5 cycles -> free accepted first, alloc next, lookup last; lookup response held stable until rdy; no lookup accepted while its response register is full.

Source files
------------

// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared TCP receive-path types and flow-table constants
package tcp_pkg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } four_tuple_struct;

    localparam int FOUR_TUPLE_STRUCT_W = $bits(four_tuple_struct);

    // Default table geometry; the flow table itself is parametrised independently.
    localparam int FLOW_TABLE_MAX_FLOWS = 8;
    localparam int FLOW_TABLE_FLOWID_W  = $clog2(FLOW_TABLE_MAX_FLOWS);
    localparam int FLOW_TABLE_PTR_W     = FLOW_TABLE_FLOWID_W + 1;

    typedef struct packed {
        logic                           ok;
        logic                           dup;
        logic [FLOW_TABLE_FLOWID_W-1:0] flowid;
    } flow_table_alloc_resp_struct;

    typedef enum logic {
        FT_INIT,
        FT_RUN
    } flow_table_state_e;

endpackage

// File: rtl/tcp_flow_free_list.sv
// rtl/tcp_flow_free_list.sv - circular FIFO of unused flowids with reset-time fill
module tcp_flow_free_list #(
    parameter int DEPTH = 8,
    parameter int ID_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fill,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head_id,
    output logic            empty,
    output logic            fill_last
);

    localparam logic [ID_W:0] PTR_ONE  = (ID_W + 1)'(1);
    localparam logic [ID_W:0] PTR_LAST = (ID_W + 1)'(DEPTH - 1);

    logic [ID_W-1:0] mem [DEPTH];
    logic [ID_W:0]   wr_ptr;
    logic [ID_W:0]   rd_ptr;

    assign head_id   = mem[rd_ptr[ID_W-1:0]];
    assign empty     = (wr_ptr == rd_ptr);
    assign fill_last = (wr_ptr == PTR_LAST);

    // Pointer update; the MSB distinguishes full from empty after wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fill || push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write: during fill each slot receives its own index
    always_ff @(posedge clk) begin
        if (fill) begin
            mem[wr_ptr[ID_W-1:0]] <= wr_ptr[ID_W-1:0];
        end else if (push) begin
            mem[wr_ptr[ID_W-1:0]] <= push_id;
        end
    end

endmodule

// File: rtl/tcp_rx_flow_table.sv
// rtl/tcp_rx_flow_table.sv - 4-tuple to flowid table with alloc, free and lookup
module tcp_rx_flow_table
    import tcp_pkg::*;
#(
    parameter int MAX_FLOWS = 8,
    parameter int FLOWID_W  = $clog2(MAX_FLOWS),
    parameter int TAG_W     = FOUR_TUPLE_STRUCT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_req_val,
    input  logic [TAG_W-1:0]    lookup_req_tag,
    output logic                lookup_req_rdy,
    output logic                lookup_resp_val,
    output logic                lookup_resp_hit,
    output logic [FLOWID_W-1:0] lookup_resp_flowid,
    input  logic                lookup_resp_rdy,
    input  logic                alloc_req_val,
    input  logic [TAG_W-1:0]    alloc_req_tag,
    output logic                alloc_req_rdy,
    output logic                alloc_resp_val,
    output logic                alloc_resp_ok,
    output logic                alloc_resp_dup,
    output logic [FLOWID_W-1:0] alloc_resp_flowid,
    input  logic                alloc_resp_rdy,
    input  logic                free_req_val,
    input  logic [FLOWID_W-1:0] free_req_flowid,
    output logic                free_req_rdy,
    output logic                err_double_free,
    output logic [FLOWID_W:0]   occupancy
);

    localparam logic [FLOWID_W:0] OCC_ONE = (FLOWID_W + 1)'(1);

    flow_table_state_e state, state_next;

    logic [MAX_FLOWS-1:0] valid;
    logic [TAG_W-1:0]     tags [MAX_FLOWS];
    logic [FLOWID_W:0]    occ;

    logic                 fill_last;
    logic                 fl_empty;
    logic [FLOWID_W-1:0]  fl_head;
    logic                 fl_push;
    logic                 fl_pop;

    logic                 free_fire;
    logic                 alloc_fire;
    logic                 lookup_fire;
    logic                 free_hit;

    logic [TAG_W-1:0]     cam_key;
    logic                 cam_hit;
    logic [FLOWID_W-1:0]  cam_id;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FT_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and request handshakes: free beats alloc beats lookup
    always_comb begin
        state_next     = state;
        free_req_rdy   = 1'b0;
        alloc_req_rdy  = 1'b0;
        lookup_req_rdy = 1'b0;
        case (state)
            FT_INIT: begin
                if (fill_last) begin
                    state_next = FT_RUN;
                end
            end
            FT_RUN: begin
                free_req_rdy   = 1'b1;
                alloc_req_rdy  = !free_req_val &&
                                 (!alloc_resp_val || alloc_resp_rdy);
                lookup_req_rdy = !free_req_val && !alloc_req_val &&
                                 (!lookup_resp_val || lookup_resp_rdy);
            end
            default: state_next = FT_INIT;
        endcase
    end

    assign free_fire   = free_req_val & free_req_rdy;
    assign alloc_fire  = alloc_req_val & alloc_req_rdy;
    assign lookup_fire = lookup_req_val & lookup_req_rdy;

    // One match array serves both alloc and lookup since only one is accepted per cycle
    assign cam_key = alloc_req_val ? alloc_req_tag : lookup_req_tag;

    // Associative match of the key against every live entry
    always_comb begin
        cam_hit = 1'b0;
        cam_id  = '0;
        for (int i = 0; i < MAX_FLOWS; i++) begin
            if (valid[i] && (tags[i] == cam_key)) begin
                cam_hit = 1'b1;
                cam_id  = FLOWID_W'(i);
            end
        end
    end

    assign free_hit = valid[free_req_flowid];
    assign fl_push  = free_fire & free_hit;
    assign fl_pop   = alloc_fire & !cam_hit & !fl_empty;

    tcp_flow_free_list #(
        .DEPTH (MAX_FLOWS),
        .ID_W  (FLOWID_W)
    ) u_free_list (
        .clk       (clk),
        .rst       (rst),
        .fill      (state == FT_INIT),
        .push      (fl_push),
        .push_id   (free_req_flowid),
        .pop       (fl_pop),
        .head_id   (fl_head),
        .empty     (fl_empty),
        .fill_last (fill_last)
    );

    // Valid bits, occupancy and the double-free pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            valid           <= '0;
            occ             <= '0;
            err_double_free <= 1'b0;
        end else begin
            err_double_free <= free_fire & !free_hit;
            if (fl_push) begin
                valid[free_req_flowid] <= 1'b0;
                occ                    <= occ - OCC_ONE;
            end else if (fl_pop) begin
                valid[fl_head] <= 1'b1;
                occ            <= occ + OCC_ONE;
            end
        end
    end

    // Tag storage for newly created entries
    always_ff @(posedge clk) begin
        if (fl_pop) begin
            tags[fl_head] <= alloc_req_tag;
        end
    end

    // Lookup response register, held until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            lookup_resp_val    <= 1'b0;
            lookup_resp_hit    <= 1'b0;
            lookup_resp_flowid <= '0;
        end else if (lookup_fire) begin
            lookup_resp_val    <= 1'b1;
            lookup_resp_hit    <= cam_hit;
            lookup_resp_flowid <= cam_hit ? cam_id : '0;
        end else if (lookup_resp_rdy) begin
            lookup_resp_val <= 1'b0;
        end
    end

    // Alloc response register: duplicate, table-full or newly created entry
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_resp_val    <= 1'b0;
            alloc_resp_ok     <= 1'b0;
            alloc_resp_dup    <= 1'b0;
            alloc_resp_flowid <= '0;
        end else if (alloc_fire) begin
            alloc_resp_val    <= 1'b1;
            alloc_resp_ok     <= !cam_hit && !fl_empty;
            alloc_resp_dup    <= cam_hit;
            alloc_resp_flowid <= cam_hit  ? cam_id :
                                 fl_empty ? '0     : fl_head;
        end else if (alloc_resp_rdy) begin
            alloc_resp_val <= 1'b0;
        end
    end

    assign occupancy = occ;

endmodule

// File: tb/tb_tcp_rx_flow_table.sv
// tb/tb_tcp_rx_flow_table.sv - self-checking bench for tcp_rx_flow_table
module tb_tcp_rx_flow_table;
    import tcp_pkg::*;

    localparam int TW = FOUR_TUPLE_STRUCT_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_req_val;
    logic [TW-1:0] lookup_req_tag;
    logic          lookup_req_rdy;
    logic          lookup_resp_val;
    logic          lookup_resp_hit;
    logic [2:0]    lookup_resp_flowid;
    logic          lookup_resp_rdy;
    logic          alloc_req_val;
    logic [TW-1:0] alloc_req_tag;
    logic          alloc_req_rdy;
    logic          alloc_resp_val;
    logic          alloc_resp_ok;
    logic          alloc_resp_dup;
    logic [2:0]    alloc_resp_flowid;
    logic          alloc_resp_rdy;
    logic          free_req_val;
    logic [2:0]    free_req_flowid;
    logic          free_req_rdy;
    logic          err_double_free;
    logic [3:0]    occupancy;

    tcp_rx_flow_table #(.MAX_FLOWS(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .lookup_req_val     (lookup_req_val),
        .lookup_req_tag     (lookup_req_tag),
        .lookup_req_rdy     (lookup_req_rdy),
        .lookup_resp_val    (lookup_resp_val),
        .lookup_resp_hit    (lookup_resp_hit),
        .lookup_resp_flowid (lookup_resp_flowid),
        .lookup_resp_rdy    (lookup_resp_rdy),
        .alloc_req_val      (alloc_req_val),
        .alloc_req_tag      (alloc_req_tag),
        .alloc_req_rdy      (alloc_req_rdy),
        .alloc_resp_val     (alloc_resp_val),
        .alloc_resp_ok      (alloc_resp_ok),
        .alloc_resp_dup     (alloc_resp_dup),
        .alloc_resp_flowid  (alloc_resp_flowid),
        .alloc_resp_rdy     (alloc_resp_rdy),
        .free_req_val       (free_req_val),
        .free_req_flowid    (free_req_flowid),
        .free_req_rdy       (free_req_rdy),
        .err_double_free    (err_double_free),
        .occupancy          (occupancy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a set of live (flowid, tag) pairs, a FIFO of free ids,
    // and the pending contents of each response channel.
    bit            m_valid [8];
    logic [TW-1:0] m_tag   [8];
    int            m_freeq [$];
    bit            m_lv, m_lhit;
    int            m_lid;
    bit            m_av, m_aok, m_adup;
    int            m_aid;
    bit            m_err;

    logic [TW-1:0] pool [12];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input logic [TW-1:0] t);
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_tag[i] == t) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_freeq.delete();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_freeq.push_back(i);
        end
        m_lv  = 1'b0;
        m_av  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic init_phase();
        for (int k = 0; k < 8; k++) begin
            #4;
            chk("init_free_rdy", free_req_rdy, 0);
            chk("init_alloc_rdy", alloc_req_rdy, 0);
            chk("init_lookup_rdy", lookup_req_rdy, 0);
            chk("init_occupancy", occupancy, 0);
            @(posedge clk);
            #1;
        end
    endtask

    // One clock cycle: drive, check against model, advance model, step clock
    task automatic cyc(input bit fv, input int fid, input bit av, input logic [TW-1:0] at,
                       input bit lv, input logic [TW-1:0] lt, input bit lr, input bit ar);
        bit e_ardy, e_lrdy;
        int hid;
        free_req_val    = fv;
        free_req_flowid = 3'(fid);
        alloc_req_val   = av;
        alloc_req_tag   = at;
        lookup_req_val  = lv;
        lookup_req_tag  = lt;
        lookup_resp_rdy = lr;
        alloc_resp_rdy  = ar;
        #4;
        e_ardy = !fv && (!m_av || ar);
        e_lrdy = !fv && !av && (!m_lv || lr);
        chk("free_req_rdy", free_req_rdy, 1);
        chk("alloc_req_rdy", alloc_req_rdy, e_ardy);
        chk("lookup_req_rdy", lookup_req_rdy, e_lrdy);
        chk("lookup_resp_val", lookup_resp_val, m_lv);
        if (m_lv) begin
            chk("lookup_resp_hit", lookup_resp_hit, m_lhit);
            chk("lookup_resp_flowid", lookup_resp_flowid, m_lid);
        end
        chk("alloc_resp_val", alloc_resp_val, m_av);
        if (m_av) begin
            chk("alloc_resp_ok", alloc_resp_ok, m_aok);
            chk("alloc_resp_dup", alloc_resp_dup, m_adup);
            chk("alloc_resp_flowid", alloc_resp_flowid, m_aid);
        end
        chk("occupancy", occupancy, 8 - m_freeq.size());
        chk("err_double_free", err_double_free, m_err);

        m_err = 1'b0;
        if (fv) begin
            if (m_valid[fid]) begin
                m_valid[fid] = 1'b0;
                m_freeq.push_back(fid);
            end else begin
                m_err = 1'b1;
            end
        end
        if (av && e_ardy) begin
            hid  = find(at);
            m_av = 1'b1;
            if (hid >= 0) begin
                m_aok = 1'b0; m_adup = 1'b1; m_aid = hid;
            end else if (m_freeq.size() == 0) begin
                m_aok = 1'b0; m_adup = 1'b0; m_aid = 0;
            end else begin
                m_aid = m_freeq.pop_front();
                m_valid[m_aid] = 1'b1;
                m_tag[m_aid]   = at;
                m_aok = 1'b1; m_adup = 1'b0;
            end
        end else if (m_av && ar) begin
            m_av = 1'b0;
        end
        if (lv && e_lrdy) begin
            hid    = find(lt);
            m_lv   = 1'b1;
            m_lhit = (hid >= 0);
            m_lid  = (hid >= 0) ? hid : 0;
        end else if (m_lv && lr) begin
            m_lv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, '0, 0, '0, 1, 1);
    endtask
    task automatic do_alloc(input logic [TW-1:0] t);
        cyc(0, 0, 1, t, 0, '0, 1, 1);
    endtask
    task automatic do_look(input logic [TW-1:0] t);
        cyc(0, 0, 0, '0, 1, t, 1, 1);
    endtask
    task automatic do_free(input int id);
        cyc(1, id, 0, '0, 0, '0, 1, 1);
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            pool[i] = {$urandom, $urandom, $urandom};
            pool[i][7:0] = 8'(i);
        end
        rst = 1'b1;
        free_req_val = 0; free_req_flowid = '0;
        alloc_req_val = 0; alloc_req_tag = '0;
        lookup_req_val = 0; lookup_req_tag = '0;
        lookup_resp_rdy = 1; alloc_resp_rdy = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        init_phase();

        // Alloc A, lookup A, lookup unused B
        do_alloc(pool[0]);
        chk("A_ok", alloc_resp_ok, 1);
        chk("A_flowid", alloc_resp_flowid, 0);
        do_look(pool[0]);
        chk("lookA_hit", lookup_resp_hit, 1);
        chk("lookA_flowid", lookup_resp_flowid, 0);
        do_look(pool[11]);
        chk("lookB_hit", lookup_resp_hit, 0);
        chk("lookB_flowid", lookup_resp_flowid, 0);

        // Duplicate insert
        do_alloc(pool[0]);
        chk("dupA_dup", alloc_resp_dup, 1);
        chk("dupA_ok", alloc_resp_ok, 0);
        chk("dupA_flowid", alloc_resp_flowid, 0);
        chk("dupA_occ", occupancy, 1);

        // Fill the table, then one more
        for (int i = 1; i < 8; i++) begin
            do_alloc(pool[i]);
            chk("fill_flowid", alloc_resp_flowid, i);
        end
        chk("full_occ", occupancy, 8);
        do_alloc(pool[8]);
        chk("full_ok", alloc_resp_ok, 0);
        chk("full_dup", alloc_resp_dup, 0);
        chk("full_flowid", alloc_resp_flowid, 0);

        // Recycling order and stale lookup
        do_free(3);
        do_free(5);
        do_alloc(pool[8]);
        chk("C_flowid", alloc_resp_flowid, 3);
        do_alloc(pool[9]);
        chk("D_flowid", alloc_resp_flowid, 5);
        do_look(pool[3]);
        chk("stale_hit", lookup_resp_hit, 0);

        // Release of a re-allocated id, then a true double free
        do_free(3);
        chk("free3_err", err_double_free, 0);
        do_free(3);
        chk("dbl_err", err_double_free, 1);
        chk("dbl_occ", occupancy, 7);
        idle();
        chk("dbl_err_pulse", err_double_free, 0);
        do_alloc(pool[10]);
        chk("reuse_flowid", alloc_resp_flowid, 3);

        // Same-cycle free/alloc/lookup with lookup consumer stalled
        cyc(1, 6, 1, pool[3], 1, pool[1], 0, 1);
        chk("prio_occ", occupancy, 7);
        cyc(0, 0, 1, pool[3], 1, pool[1], 0, 1);
        chk("prio_alloc_flowid", alloc_resp_flowid, 6);
        cyc(0, 0, 0, '0, 1, pool[1], 0, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, '0, 1, pool[2], 0, 1);
        end
        chk("held_flowid", lookup_resp_flowid, 1);
        cyc(0, 0, 0, '0, 1, pool[2], 1, 1);
        idle();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(3) == 0, $urandom_range(7),
                $urandom_range(2) == 0, pool[$urandom_range(11)],
                $urandom_range(1) == 1, pool[$urandom_range(11)],
                $urandom_range(3) != 0, $urandom_range(3) != 0);
        end

        // Reset with responses pending
        idle();
        cyc(0, 0, 1, pool[11], 1, pool[0], 0, 0);
        free_req_val = 0; alloc_req_val = 0; lookup_req_val = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_lookup_val", lookup_resp_val, 0);
        chk("rst_alloc_val", alloc_resp_val, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_err", err_double_free, 0);
        rst = 1'b0;
        model_reset();
        init_phase();
        do_look(pool[0]);
        chk("post_rst_hit", lookup_resp_hit, 0);
        do_alloc(pool[5]);
        chk("post_rst_flowid", alloc_resp_flowid, 0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
